power_q10: RTL
==============

Name: power_q10

Overview:
- Sequential fixed-point power unit: computes out = x^n, with x unsigned Q10.10 and integer exponent n in 0..7.
- It is the inverse companion of the team's n-th root block. It takes that block's Q10.10 result format as input and is used to check and reconstruct root outputs.
- Uses one 20x20 multiply per cycle with truncation to Q10.10 after each step. Saturates on overflow.
- Sits beside the root/division blocks on the same single-pulse valid handshake.

Parameters:
- FRAC_BITS, 10, fractional bits of the Q format. Fixed at 10; only the value 10 is verified.
- DATA_W, 20, total operand/result width (Q10.10).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  one-cycle start pulse; in_data_1/in_data_2 are sampled on this cycle
- in_data_1  input  20  base x, unsigned Q10.10
- in_data_2  input  3  exponent n, 0..7
- out_valid  output  1  one-cycle result strobe
- out_data  output  20  result, unsigned Q10.10; held between strobes
- out_ovf  output  1  result saturated; valid when out_valid=1, held afterwards

Behaviour:
- Reset, on any clk edge with rst_n=0:
  - state=IDLE, out_valid=0, out_data=0, out_ovf=0.
  - Internal base, acc, cnt and ovf all cleared.
  - Reset mid-operation aborts with no out_valid pulse. The first in_valid after reset release is accepted normally.
- FSM states: IDLE, MUL.
- IDLE, in_valid=1, sampled at edge E0:
  - base<=in_data_1, acc<=20'h00400 (1.0), cnt<=in_data_2, ovf<=0.
  - If in_data_2=0: remain IDLE; out_valid<=1, out_data<=20'h00400, out_ovf<=0.
  - Else: go to MUL.
- MUL, at each edge:
  - p = acc*base (40b); q = p>>10 (truncate toward zero, 30b).
  - If ovf, or q[29:20]!=0: acc<=20'hFFFFF and ovf<=1. Else acc<=q[19:0].
  - Sticky: once saturated, later steps keep 20'hFFFFF, even if base=0.
  - cnt<=cnt-1.
  - When cnt==1 (last step): out_valid<=1, out_data<=the new acc value, out_ovf<=the new ovf value, next state IDLE.
- Latency:
  - in_valid sampled in cycle T gives out_valid high in cycle T+n+1 for n>=1, and in cycle T+1 for n=0.
  - Exactly one out_valid cycle per accepted request.
- out_valid is registered and auto-clears the following cycle.
- out_data and out_ovf keep their last value until the next result.
- in_valid while in MUL is ignored: no queueing, and the operands in flight are unaffected.
- in_valid in the same cycle that out_valid is high is accepted, because the state is already IDLE. Back-to-back throughput is n+1 cycles per request.
- The exponent is a pure integer, so there is no fractional-exponent path. x=0 with n>=1 gives 0. 0^0 = 1.0.
- No combinational path from inputs to outputs.

Test Plan:
- x=20'h00800 (2.0), n=3 at cycle T -> out_valid only in T+4, out_data=20'h02000 (8.0), out_ovf=0.
- x=20'h00600 (1.5), n=2 -> 20'h00900 (2.25). x=20'h00200 (0.5), n=7 -> 20'h00008. x=20'h00001, n=2 -> 20'h00000 (truncation).
- x=20'h07C00 (31.0), n=2 -> 20'hF0400, ovf=0. x=20'h08000 (32.0), n=2 -> 20'hFFFFF, ovf=1. x=20'h08000, n=3 -> 20'hFFFFF, ovf=1 (sticky).
- n=0 with x=20'h12345 -> out_valid at T+1, out_data=20'h00400. Immediately follow with in_valid in that same cycle (x=2.0, n=1) -> second out_valid at T+3, out_data=20'h00800.
- Start x=2.0, n=7; pulse in_valid with x=3.0 at cycle T+2 -> ignored; a single result 20'h1FC00... must not occur. Required result is 128.0 = 20'h20000 at T+8 with ovf=0; check the exact value.
- Start n=5, assert rst_n=0 at T+2 for 1 cycle -> no out_valid ever for that request, outputs all 0. A fresh request x=1.0, n=4 afterwards -> 20'h00400 after 5 cycles.

Source files
------------

// File: rtl/power_q10.sv
// power_q10: sequential unsigned Q10.10 power unit, out = x^n, n in 0..7.
// One truncating 20x20 multiply per cycle, sticky saturation on overflow.
module power_q10 #(
  parameter int FRAC_BITS = 10,
  parameter int DATA_W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [2:0]        in_data_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int QW = PW - FRAC_BITS;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_BITS);
  localparam logic [DATA_W-1:0] SAT = '1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              oo_q, oo_d;

  logic [PW-1:0]     prod;
  logic [QW-1:0]     q;
  logic              sat;
  logic [DATA_W-1:0] step;

  // Product is truncated toward zero back to Q10.10; anything above
  // the integer field, or an earlier overflow, pins the result.
  assign prod = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, base_q};
  assign q    = QW'(prod >> FRAC_BITS);
  assign sat  = ovf_q | (|q[QW-1:DATA_W]);
  assign step = sat ? SAT : q[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    oo_d    = oo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          base_d = in_data_1;
          acc_d  = ONE;
          cnt_d  = in_data_2;
          ovf_d  = 1'b0;
          if (in_data_2 == 3'd0) begin
            ov_d = 1'b1;
            od_d = ONE;
            oo_d = 1'b0;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d = step;
        ovf_d = sat;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          ov_d    = 1'b1;
          od_d    = step;
          oo_d    = sat;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oo_q    <= oo_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_ovf   = oo_q;

endmodule
